// File: rtl/times_table_pkg.sv
// Shared types, constants and the address map for the times-table read arbiter.
package times_table_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [23:0] TT_BASE   = 24'd0;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  // One 32-bit word per (a, b) pair, so the operands form the word index.
  function automatic logic [ADDR_W-1:0] tt_addr(input logic [2:0] a, input logic [2:0] b);
    return {TT_BASE, a, b, 2'b00};
  endfunction

endpackage

// File: rtl/times_table_read_arbiter_if.sv
// Requester-side and AXI4-lite read-channel signals of the times-table arbiter.
interface times_table_read_arbiter_if
  import times_table_pkg::*;
();

  logic [1:0]        req;
  logic [2:0]        a0;
  logic [2:0]        b0;
  logic [2:0]        a1;
  logic [2:0]        b1;
  logic [1:0]        ack;
  logic [5:0]        result;
  logic              err;
  logic              busy;

  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  // The arbiter: consumes requests, masters the AXI read channel.
  modport master (
    input  req, a0, b0, a1, b1,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output ack, result, err, busy,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

  // The environment: requesters plus the memory's read port.
  modport slave (
    output req, a0, b0, a1, b1,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  ack, result, err, busy,
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

endinterface

// File: rtl/times_table_read_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves away from the requester just served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_update_id,
  output logic [1:0] o_grant
);

  // r_ptr names the requester favoured on a tie.
  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_update) begin
      r_ptr <= ~i_update_id;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign o_grant[gi] = i_req[gi] && (!i_req[1-gi] || (r_ptr == 1'(gi)));
  end

endmodule

// File: rtl/times_table_read_arbiter.sv
// Serialises two requesters' times-table lookups onto one AXI4-lite read port.
module times_table_read_arbiter
  import times_table_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  times_table_read_arbiter_if.master  bus
);

  state_t            r_state;
  logic              r_id;
  logic [1:0]        r_ack;
  logic [5:0]        r_result;
  logic              r_err;
  logic              r_busy;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_arvalid;
  logic              r_rready;

  logic [1:0]        w_grant;
  logic              w_win_id;
  logic [2:0]        w_a;
  logic [2:0]        w_b;
  logic              w_ptr_upd;

  assign w_ptr_upd = (r_state == RESP);

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .i_req       (bus.req),
    .i_update    (w_ptr_upd),
    .i_update_id (r_id),
    .o_grant     (w_grant)
  );

  assign w_win_id = w_grant[1];
  assign w_a      = w_win_id ? bus.a1 : bus.a0;
  assign w_b      = w_win_id ? bus.b1 : bus.b0;

  // Operands are folded into r_araddr at grant, so later operand changes are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_id      <= 1'b0;
      r_ack     <= 2'b00;
      r_result  <= 6'd0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_id      <= w_win_id;
            r_araddr  <= tt_addr(w_a, w_b);
            r_arvalid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (bus.m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_result <= bus.m_axi_rdata[5:0];
            r_err    <= (bus.m_axi_rresp != RESP_OKAY);
            r_ack    <= r_id ? 2'b10 : 2'b01;
            r_state  <= RESP;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack           = r_ack;
  assign bus.result        = r_result;
  assign bus.err           = r_err;
  assign bus.busy          = r_busy;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;

endmodule
